// File: rtl/axi_lite_final_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_final_regs
//
// AXI4-Lite slave register file. Decodes the byte window
// C_BASEADDR..C_HIGHADDR and holds C_NUM_REG 32-bit read/write registers.
// Single-beat writes with byte strobes and single-beat reads; at most one
// write and one read are outstanding at a time. The two channels run
// independently of each other.
//
// Optional feature (compile-time macro AXI_LITE_FINAL_PROT_EN):
//   defined   - accesses with PROT[0]=0 get SLVERR; the write is dropped
//               and a read returns 0.
//   undefined - AWPROT/ARPROT are ignored.
//
// Ports:
//   ACLK, ARESETN          clock (rising edge), async active-low reset
//   S_AXI_AW*              write address channel (ADDR, PROT, VALID, READY)
//   S_AXI_W*               write data channel (DATA, STRB, VALID, READY)
//   S_AXI_B*               write response channel (RESP, VALID, READY)
//   S_AXI_AR*              read address channel (ADDR, PROT, VALID, READY)
//   S_AXI_R*               read data channel (DATA, RESP, VALID, READY)
// ---------------------------------------------------------------------------
module axi_lite_final_regs #(
  parameter logic [31:0] C_BASEADDR         = 32'h8800_0000,
  parameter logic [31:0] C_HIGHADDR         = 32'h8800_01FF,
  parameter logic [31:0] C_S_AXI_MIN_SIZE   = 32'h0000_01FF,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_NUM_REG          = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int ADDR_W   = C_S_AXI_ADDR_WIDTH;
  localparam int DATA_W   = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W   = DATA_W / 8;
  localparam int LOG2_REG = $clog2(C_NUM_REG);
  // A single-register build still needs a one-bit index to keep slices legal.
  localparam int IDX_W    = (LOG2_REG > 0) ? LOG2_REG : 1;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(C_BASEADDR);
  localparam logic [ADDR_W-1:0] HIGH = ADDR_W'(C_HIGHADDR);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_LITE_FINAL_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic [DATA_W-1:0] regs [C_NUM_REG];

  logic              aw_ready, w_ready, b_valid;
  logic [1:0]        b_resp;
  logic              ar_ready, r_valid;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_data;

  logic [ADDR_W-1:0] wr_offset, rd_offset;
  logic              wr_in_win, rd_in_win, wr_mapped, rd_mapped;
  logic              wr_prot_ok, rd_prot_ok, wr_en, wr_fire, rd_fire;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [1:0]        wr_resp, rd_resp;
  logic [DATA_W-1:0] rd_value;
  logic              unused_bits;

  // Address decode for both channels. In-window addresses beyond the last
  // register are still OKAY but read as zero and ignore writes; only
  // out-of-window (or, with the protection check, unprivileged) accesses
  // produce SLVERR.
  always_comb begin
    wr_in_win  = (S_AXI_AWADDR >= BASE) && (S_AXI_AWADDR <= HIGH);
    wr_offset  = S_AXI_AWADDR - BASE;
    wr_mapped  = (wr_offset[ADDR_W-1:2] >> LOG2_REG) == '0;
    wr_idx     = wr_offset[IDX_W+1:2];
    wr_prot_ok = !PROT_EN || S_AXI_AWPROT[0];
    wr_resp    = (wr_in_win && wr_prot_ok) ? RESP_OKAY : RESP_SLVERR;
    wr_en      = wr_in_win && wr_prot_ok && wr_mapped;

    rd_in_win  = (S_AXI_ARADDR >= BASE) && (S_AXI_ARADDR <= HIGH);
    rd_offset  = S_AXI_ARADDR - BASE;
    rd_mapped  = (rd_offset[ADDR_W-1:2] >> LOG2_REG) == '0;
    rd_idx     = rd_offset[IDX_W+1:2];
    rd_prot_ok = !PROT_EN || S_AXI_ARPROT[0];
    rd_resp    = (rd_in_win && rd_prot_ok) ? RESP_OKAY : RESP_SLVERR;
    rd_value   = (rd_in_win && rd_prot_ok && rd_mapped) ? regs[rd_idx] : '0;
  end

  // Byte offsets within a word and PROT bits are deliberately not decoded.
  assign unused_bits = ^{wr_offset[1:0], rd_offset[1:0], S_AXI_AWPROT, S_AXI_ARPROT};

  // A handshake cycle is one where our registered ready pulse meets the
  // master's still-asserted valids.
  assign wr_fire = aw_ready && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = ar_ready && S_AXI_ARVALID;

  // Write address/data/response. AW and W are accepted together only, and
  // never while a response is still waiting, so BRESP cannot change under
  // a pending BVALID.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
    end else begin
      aw_ready <= S_AXI_AWVALID && S_AXI_WVALID && !aw_ready && !b_valid;
      w_ready  <= S_AXI_AWVALID && S_AXI_WVALID && !aw_ready && !b_valid;
      if (wr_fire) begin
        b_valid <= 1'b1;
        b_resp  <= wr_resp;
      end else if (b_valid && S_AXI_BREADY) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Register storage with per-byte write enables.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < C_NUM_REG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire && wr_en) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (S_AXI_WSTRB[k]) begin
          regs[wr_idx][8*k +: 8] <= S_AXI_WDATA[8*k +: 8];
        end
      end
    end
  end

  // Read address/data. Data is sampled from the register array on the
  // handshake edge, so a same-edge write to the same register is not seen.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= RESP_OKAY;
      r_data   <= '0;
    end else begin
      ar_ready <= S_AXI_ARVALID && !ar_ready && !r_valid;
      if (rd_fire) begin
        r_valid <= 1'b1;
        r_resp  <= rd_resp;
        r_data  <= rd_value;
      end else if (r_valid && S_AXI_RREADY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RRESP   = r_resp;
  assign S_AXI_RDATA   = r_data;

endmodule

// File: tb/tb_axi_lite_final_regs.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_final_regs
//
// Self-checking bench for axi_lite_final_regs. A behavioural model (plain
// word array plus address arithmetic) predicts every response and read
// value; directed sequences cover the basic behaviours and a randomized
// phase mixes reads and writes over mapped, unmapped and out-of-window
// addresses.
// ---------------------------------------------------------------------------
module tb_axi_lite_final_regs;

  localparam logic [31:0] BASE    = 32'h8800_0000;
  localparam logic [31:0] HIGH    = 32'h8800_01FF;
  localparam int          NUM_REG = 4;

`ifdef AXI_LITE_FINAL_PROT_EN
  localparam bit PROT_CHECK = 1'b1;
`else
  localparam bit PROT_CHECK = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] modelRegs [NUM_REG];

  axi_lite_final_regs dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  // 100 MHz clock
  always #5 ACLK = ~ACLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Model: response is decided by the window and, optionally, privilege.
  function automatic logic [1:0] modelResp(input logic [31:0] addr, input logic [2:0] prot);
    if (addr < BASE || addr > HIGH) return 2'b10;
    if (PROT_CHECK && !prot[0]) return 2'b10;
    return 2'b00;
  endfunction

  // Model: word number inside the window, or -1 when no register lives there.
  function automatic int modelWord(input logic [31:0] addr);
    longint unsigned word;
    word = longint'(addr - BASE) / 4;
    if (word < NUM_REG) return int'(word);
    return -1;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr, input logic [2:0] prot);
    int w;
    if (modelResp(addr, prot) != 2'b00) return 32'h0;
    w = modelWord(addr);
    if (w < 0) return 32'h0;
    return modelRegs[w];
  endfunction

  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot);
    int w;
    if (modelResp(addr, prot) != 2'b00) return;
    w = modelWord(addr);
    if (w < 0) return;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) modelRegs[w][8*k +: 8] = data[8*k +: 8];
    end
  endtask

  // One write transaction. holdCycles>0 keeps BREADY low that long while a
  // second AW/W is offered, which must not be taken.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [2:0] prot,
                               input int holdCycles);
    int n;
    logic [1:0] expResp;
    expResp = modelResp(addr, prot);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = addr; S_AXI_AWPROT = prot; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!S_AXI_AWREADY && n < 20);
    checkOutput("aw_latency", n, 2);
    checkOutput("wready_with_awready", S_AXI_WREADY, 1'b1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    modelWrite(addr, data, strb, prot);
    checkOutput("awready_one_cycle", S_AXI_AWREADY, 1'b0);
    checkOutput("bvalid_after_hs", S_AXI_BVALID, 1'b1);
    checkOutput("bresp", S_AXI_BRESP, expResp);
    if (holdCycles > 0) begin
      S_AXI_AWADDR = BASE; S_AXI_AWPROT = 3'b001; S_AXI_WDATA = 32'hFFFF_FFFF;
      S_AXI_WSTRB = 4'hF; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      for (int i = 0; i < holdCycles; i++) begin
        @(negedge ACLK);
        checkOutput("bvalid_hold", S_AXI_BVALID, 1'b1);
        checkOutput("bresp_stable", S_AXI_BRESP, expResp);
        checkOutput("aw_blocked", S_AXI_AWREADY, 1'b0);
      end
      @(posedge ACLK); #1;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    checkOutput("bvalid_clear", S_AXI_BVALID, 1'b0);
  endtask

  // One read transaction, checked against the model; data is returned for
  // extra directed checks by the caller.
  task automatic applyRead(input logic [31:0] addr, input logic [2:0] prot,
                           input int waitCycles, output logic [31:0] data);
    int n;
    logic [31:0] expData;
    logic [1:0]  expResp;
    expData = modelRead(addr, prot);
    expResp = modelResp(addr, prot);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = addr; S_AXI_ARPROT = prot; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!S_AXI_ARREADY && n < 20);
    checkOutput("ar_latency", n, 2);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    checkOutput("arready_one_cycle", S_AXI_ARREADY, 1'b0);
    checkOutput("rvalid_after_hs", S_AXI_RVALID, 1'b1);
    checkOutput("rdata", S_AXI_RDATA, expData);
    checkOutput("rresp", S_AXI_RRESP, expResp);
    data = S_AXI_RDATA;
    for (int i = 0; i < waitCycles; i++) begin
      @(negedge ACLK);
      checkOutput("rvalid_hold", S_AXI_RVALID, 1'b1);
      checkOutput("rdata_stable", S_AXI_RDATA, expData);
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    checkOutput("rvalid_clear", S_AXI_RVALID, 1'b0);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 5))
      0, 1, 2: return BASE + 32'($urandom_range(0, NUM_REG - 1)) * 4 + 32'($urandom_range(0, 3));
      3:       return BASE + 32'($urandom_range(0, 127)) * 4;
      4:       return BASE + 32'h200 + 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  // Safety net in case a handshake never completes.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] oldVal;
    logic [31:0] newVal;
    int n;

    for (int i = 0; i < NUM_REG; i++) modelRegs[i] = 32'h0;

    // Valids asserted during reset must not provoke any response.
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    #250;
    checkOutput("reset_awready", S_AXI_AWREADY, 1'b0);
    checkOutput("reset_wready",  S_AXI_WREADY,  1'b0);
    checkOutput("reset_bvalid",  S_AXI_BVALID,  1'b0);
    checkOutput("reset_arready", S_AXI_ARREADY, 1'b0);
    checkOutput("reset_rvalid",  S_AXI_RVALID,  1'b0);
    checkOutput("reset_bresp",   S_AXI_BRESP,   2'b00);
    checkOutput("reset_rresp",   S_AXI_RRESP,   2'b00);
    checkOutput("reset_rdata",   S_AXI_RDATA,   32'h0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    #250;
    ARESETN = 1'b1;

    $display("[TB] reset released, reading registers");
    for (int w = 0; w < NUM_REG; w++) applyRead(BASE + 32'(w * 4), 3'b001, 0, rd);

    applyStimulus(32'h8800_0004, 32'hDEAD_BEEF, 4'hF, 3'b001, 0);
    applyRead(32'h8800_0004, 3'b001, 1, rd);
    checkOutput("full_word", rd, 32'hDEAD_BEEF);

    applyStimulus(32'h8800_0004, 32'h1122_3344, 4'h5, 3'b001, 0);
    applyRead(32'h8800_0004, 3'b001, 0, rd);
    checkOutput("strb_merge", rd, 32'hDE22_BE44);

    $display("[TB] held write response");
    applyStimulus(32'h8800_0008, 32'hCAFE_F00D, 4'hF, 3'b001, 5);
    applyRead(32'h8800_0000, 3'b001, 0, rd);
    checkOutput("blocked_write_dropped", rd, 32'h0);

    applyRead(32'h8800_0100, 3'b001, 0, rd);
    applyStimulus(32'h8800_0200, 32'h5555_AAAA, 4'hF, 3'b001, 0);
    applyRead(32'h8800_0200, 3'b001, 0, rd);
    for (int w = 0; w < NUM_REG; w++) applyRead(BASE + 32'(w * 4), 3'b001, 0, rd);

    $display("[TB] sequential word sweep");
    for (int w = 0; w < 16; w++) begin
      applyStimulus(BASE + 32'(w * 4), 32'($urandom), 4'hF, 3'b001, 0);
      applyRead(BASE + 32'(w * 4), 3'b001, 0, rd);
    end

    // Write and read handshake on the same edge to the same register.
    $display("[TB] overlapping read and write");
    oldVal = modelRead(32'h8800_000C, 3'b001);
    newVal = 32'($urandom);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 32'h8800_000C; S_AXI_AWPROT = 3'b001; S_AXI_WDATA = newVal;
    S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 32'h8800_000C; S_AXI_ARPROT = 3'b001;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!S_AXI_AWREADY && n < 20);
    checkOutput("overlap_aw_latency", n, 2);
    checkOutput("overlap_arready", S_AXI_ARREADY, 1'b1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    modelWrite(32'h8800_000C, newVal, 4'hF, 3'b001);
    checkOutput("overlap_rvalid", S_AXI_RVALID, 1'b1);
    checkOutput("overlap_old_value", S_AXI_RDATA, oldVal);
    checkOutput("overlap_bvalid", S_AXI_BVALID, 1'b1);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    applyRead(32'h8800_000C, 3'b001, 0, rd);
    checkOutput("overlap_new_value", rd, newVal);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        applyStimulus(randAddr(), 32'($urandom), 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end else begin
        applyRead(randAddr(), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/axi_lite_final_regs.md
Name: axi_lite_final_regs

Overview:
AXI4-Lite slave register file that decodes the window C_BASEADDR..C_HIGHADDR and holds C_NUM_REG 32-bit read/write registers. It sits behind an AXI4-Lite master, such as axi_lite_master, on the same ACLK domain. It accepts single-beat writes with byte strobes and single-beat reads. Only one write and one read transaction is outstanding at a time.

Parameters:
C_BASEADDR  32'h88000000  first byte address of the decoded window
C_HIGHADDR  32'h880001FF  last byte address of the decoded window (inclusive)
C_S_AXI_MIN_SIZE  32'h000001FF  window size minus 1; informational only, with C_HIGHADDR-C_BASEADDR >= C_S_AXI_MIN_SIZE
C_S_AXI_ADDR_WIDTH  32  address bus width
C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported
C_NUM_REG  4  number of 32-bit registers, power of 2, range 1..64

Ports:
ACLK  in  1  clock; all logic is on the rising edge
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWPROT  in  3  write protection
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_W  write data
S_AXI_WSTRB  in  DATA_W/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARPROT  in  3  read protection
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_W  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready

Behaviour:
- Reset (ARESETN=0, asynchronous):
  - All ready/valid outputs are 0.
  - BRESP=RRESP=2'b00 and RDATA=0.
  - All registers are 0.
- Address decode:
  - Address is in-window when C_BASEADDR <= addr <= C_HIGHADDR.
  - offset = addr - C_BASEADDR; idx = offset[log2(C_NUM_REG)+1:2]. Address bits [1:0] are ignored.
  - An in-window address with offset[ADDR_W-1:log2(C_NUM_REG)+2] != 0 is read-as-zero / write-ignored, with response OKAY.
  - An out-of-window address returns SLVERR (2'b10); writes are ignored and RDATA is 0.
- Write channel:
  - In cycle N, AWVALID&WVALID=1 while AWREADY=0 and BVALID=0. On the edge ending cycle N, AWREADY and WREADY are both registered high for exactly one cycle (cycle N+1).
  - The write is performed on the edge ending that handshake cycle. Byte lane k of reg[idx] is updated only where WSTRB[k]=1.
  - BVALID and BRESP are registered on the same edge, so BVALID is first visible the cycle after the handshake.
  - BVALID holds, with BRESP stable, until BVALID&BREADY; it clears on that edge.
  - AW or W arriving alone is never accepted; the slave waits for both.
- Read channel:
  - ARREADY pulses high for one cycle, registered on the edge after ARVALID=1, ARREADY=0, RVALID=0.
  - RDATA and RRESP are captured from the address on the handshake edge. RVALID is visible the next cycle and holds with stable data until RVALID&RREADY.
  - No new AR is accepted while RVALID=1.
- Reads and writes are fully independent and may overlap.
- Same-cycle write handshake and read handshake to the same register: the read returns the old value.
- Reset asserted mid-transaction aborts it. The pending BVALID/RVALID is dropped and the master must reissue.
- AWPROT/ARPROT are ignored unless the optional feature is enabled.

Optional Feature:
AXI_LITE_FINAL_PROT_EN
- Defined: an access with PROT[0]=0 (unprivileged) returns SLVERR. The write is dropped; a read returns 0.
- Undefined: PROT is ignored, and the response depends only on the address decode.

Test Plan:
- Reset for 500 ns, then release → all outputs 0; reading 0x88000000..0x8800000C returns 0 with OKAY.
- Write 0x88000004 data 0xDEADBEEF, WSTRB=0xF → AWREADY/WREADY pulse together one cycle after valid; BVALID next cycle with OKAY; a read returns 0xDEADBEEF.
- Write 0x11223344 with WSTRB=0x5 over 0xDEADBEEF at 0x88000004 → read returns 0xDE22BE44.
- Hold BREADY=0 for 5 cycles → BVALID stays 1 with BRESP stable; no second AW is accepted until BREADY=1.
- Read 0x88000100 (in-window, unmapped) → 0 with OKAY. Write then read 0x88000200 (out-of-window) → BRESP=RRESP=2'b10, no register changes.
- Write/read the 16 sequential words 0x88000000..0x8800003C, each write followed by a readback of the same address → words 0..3 read back the written value; words 4..15 read 0; all responses OKAY.
